cpu_step_controller: RTL and testbench



---
 rtl/cpu_step_controller_pkg.sv | 22 ++
 rtl/cpu_step_controller_edge.sv | 35 +++
 rtl/cpu_step_controller.sv | 169 ++++++++++++++++
 tb/tb_cpu_step_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_controller_pkg.sv
// cpu_step_controller_pkg
//   Shared encodings for the CPU run/step/burst scheduler: the two-bit mode
//   switch values and the scheduler FSM state encoding.
package cpu_step_controller_pkg;

  // Mode switch encoding as wired from the front panel
  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RUN       = 2'b01,
    S_STEP_WAIT = 2'b10,
    S_BURST     = 2'b11
  } state_t;

endpackage

// File: rtl/cpu_step_controller_edge.sv
// rising_edge_detect
//   Registers the previous value of a level input and produces a
//   combinational one-cycle pulse on each 0->1 transition.
//   RESET_VAL sets the remembered value after reset; loading 1 means a
//   level already high when reset releases is not seen as an edge.
// Ports:
//   clk_in  system clock
//   reset   synchronous, active-high reset
//   sig     level input
//   pulse   high for one cycle when sig rises
module rising_edge_detect
  import cpu_step_controller_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic prev_r;

  // Remember last cycle's level of the input
  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev_r <= RESET_VAL;
    end else begin
      prev_r <= sig;
    end
  end

  assign pulse = sig & ~prev_r;

endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller
//   Decides which clock-divider ticks become CPU enable pulses: every tick
//   (RUN), one tick per button press (STEP), burst_len ticks per press
//   (BURST), or none (HALT). Also counts issued enables for the display.
// Ports:
//   clk_in     system clock
//   reset      synchronous, active-high reset
//   tick_in    one-cycle pulse from the clock divider
//   mode       00 HALT, 01 RUN, 10 STEP, 11 BURST
//   step_req   debounced step button level (rising edges used)
//   burst_len  enables per burst, sampled when a burst starts
//   cpu_en     registered one-cycle CPU enable
//   busy       registered, high whenever the scheduler is not idle
//   done       registered pulse with the final enable of a step/burst
//   cycles     number of enables issued, wraps modulo 2^CYC_W
module cpu_step_controller
  import cpu_step_controller_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [CNT_W-1:0] burst_len,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};

  state_t           state_r;
  logic             cpu_en_r;
  logic             done_r;
  logic             busy_r;
  logic [CYC_W-1:0] cycles_r;
  logic [CNT_W-1:0] remaining_r;
  logic             step_edge_s;
  logic             take_s;
  mode_t            mode_s;

  assign mode_s = mode_t'(mode);

  rising_edge_detect #(
    .RESET_VAL(1'b1)
  ) u_step_edge (
    .clk_in (clk_in),
    .reset  (reset),
    .sig    (step_req),
    .pulse  (step_edge_s)
  );

  // A tick becomes an enable only in an active state that is not being
  // left this cycle; leaving RUN or aborting to HALT drops the tick.
  always_comb begin
    take_s = 1'b0;
    case (state_r)
      S_RUN: begin
        if (mode_s == MODE_RUN) take_s = tick_in;
        else                    take_s = 1'b0;
      end
      S_STEP_WAIT, S_BURST: begin
        if (mode_s != MODE_HALT) take_s = tick_in;
        else                     take_s = 1'b0;
      end
      default: take_s = 1'b0;
    endcase
  end

  // Scheduler FSM with registered enable/done/busy and the issue counter
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cpu_en_r    <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      cycles_r    <= CYC_ZERO;
      remaining_r <= CNT_ZERO;
    end else begin
      cpu_en_r <= take_s;
      done_r   <= 1'b0;
      if (take_s) cycles_r <= cycles_r + {{(CYC_W-1){1'b0}}, 1'b1};
      else        cycles_r <= cycles_r;

      case (state_r)
        S_IDLE: begin
          if (mode_s == MODE_RUN) begin
            state_r <= S_RUN;
            busy_r  <= 1'b1;
          end else if (mode_s == MODE_STEP && step_edge_s) begin
            state_r <= S_STEP_WAIT;
            busy_r  <= 1'b1;
          end else if (mode_s == MODE_BURST && step_edge_s && burst_len != CNT_ZERO) begin
            state_r     <= S_BURST;
            busy_r      <= 1'b1;
            remaining_r <= burst_len;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end

        S_RUN: begin
          if (mode_s != MODE_RUN) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= S_RUN;
            busy_r  <= 1'b1;
          end
        end

        S_STEP_WAIT: begin
          if (mode_s == MODE_HALT) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            remaining_r <= CNT_ZERO;
          end else if (tick_in) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_STEP_WAIT;
            busy_r  <= 1'b1;
          end
        end

        S_BURST: begin
          if (mode_s == MODE_HALT) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            remaining_r <= CNT_ZERO;
          end else if (tick_in) begin
            remaining_r <= remaining_r - CNT_ONE;
            if (remaining_r == CNT_ONE) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_BURST;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= S_BURST;
            busy_r  <= 1'b1;
          end
        end

        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          remaining_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign cpu_en = cpu_en_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign cycles = cycles_r;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller. The driver applies one cycle of
// inputs per negedge, advances a reference model of the scheduler (a step is
// treated as a burst of one, RUN as an unbounded stream) and queues the
// expected outputs; the monitor pops and compares after every posedge.
module tb_cpu_step_controller;
  import cpu_step_controller_pkg::*;

  localparam int CNT_W = 16;
  localparam int CYC_W = 4;

  logic             clk_in    = 1'b0;
  logic             reset     = 1'b1;
  logic             tick_in   = 1'b0;
  logic [1:0]       mode      = 2'b00;
  logic             step_req  = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic [CYC_W-1:0] cycles;

  cpu_step_controller #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .tick_in   (tick_in),
    .mode      (mode),
    .step_req  (step_req),
    .burst_len (burst_len),
    .cpu_en    (cpu_en),
    .busy      (busy),
    .done      (done),
    .cycles    (cycles)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic             en;
    logic             dn;
    logic             bs;
    logic [CYC_W-1:0] cy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;

  // Reference model: running = free-run stream, left = enables still owed
  bit               m_run  = 1'b0;
  int               m_left = 0;
  bit               m_prev = 1'b1;
  logic [CYC_W-1:0] m_cyc  = '0;

  task automatic apply(input bit r, input bit t, input logic [1:0] m,
                       input bit s, input logic [CNT_W-1:0] bl);
    exp_t e;
    bit   stp_edge;
    bit   en;
    bit   dn;
    @(negedge clk_in);
    reset = r; tick_in = t; mode = m; step_req = s; burst_len = bl;
    en = 1'b0;
    dn = 1'b0;
    if (r) begin
      m_run = 1'b0; m_left = 0; m_prev = 1'b1; m_cyc = '0;
    end else begin
      stp_edge = s && !m_prev;
      m_prev   = s;
      if (m_run) begin
        if (m == MODE_RUN) en = t;
        else m_run = 1'b0;
      end else if (m_left > 0) begin
        if (m == MODE_HALT) m_left = 0;
        else if (t) begin
          en = 1'b1;
          m_left--;
          dn = (m_left == 0);
        end
      end else if (m == MODE_RUN) m_run = 1'b1;
      else if (stp_edge && m == MODE_STEP) m_left = 1;
      else if (stp_edge && m == MODE_BURST) m_left = int'(bl);
      if (en) m_cyc = m_cyc + 4'd1;
    end
    e = {en, dn, (m_run || m_left > 0), m_cyc};
    sb_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs shortly after each active edge
  always @(posedge clk_in) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if (cpu_en !== mon_e.en || done !== mon_e.dn || busy !== mon_e.bs || cycles !== mon_e.cy) begin
        n_fail++;
        $display("FAIL outputs @%0t: cpu_en/done/busy/cycles got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 $time, cpu_en, done, busy, cycles, mon_e.en, mon_e.dn, mon_e.bs, mon_e.cy);
      end
      if (cpu_en === 1'b1) en_cnt++;
    end
  end

  task automatic check_cnt(input string nm, input int start, input int want);
    @(posedge clk_in);
    #2;
    n_tests++;
    if (en_cnt - start != want) begin
      n_fail++;
      $display("FAIL %s: got %0d enables, expected %0d", nm, en_cnt - start, want);
    end
  endtask

  initial begin
    int s;
    logic [1:0]       rm;
    bit               rstep;
    logic [CNT_W-1:0] rbl;

    repeat (2) apply(1'b1, 1'b0, MODE_HALT, 1'b0, 16'd0);
    repeat (2) apply(1'b0, 1'b0, MODE_HALT, 1'b0, 16'd0);

    // RUN: tick every 5 cycles for 50 cycles
    apply(1'b0, 1'b0, MODE_RUN, 1'b0, 16'd0);
    s = en_cnt;
    for (int i = 0; i < 50; i++) apply(1'b0, (i % 5) == 0, MODE_RUN, 1'b0, 16'd0);
    apply(1'b0, 1'b0, MODE_RUN, 1'b0, 16'd0);
    check_cnt("run_ticks", s, 10);
    apply(1'b0, 1'b0, MODE_HALT, 1'b0, 16'd0);

    // STEP: one press, three ticks
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_STEP, 1'b1, 16'd0);
    apply(1'b0, 1'b0, MODE_STEP, 1'b0, 16'd0);
    for (int i = 0; i < 12; i++) apply(1'b0, (i % 4) == 1, MODE_STEP, 1'b0, 16'd0);
    check_cnt("step_one", s, 1);

    // BURST of 4 with 6 ticks
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_BURST, 1'b1, 16'd4);
    apply(1'b0, 1'b0, MODE_BURST, 1'b0, 16'd4);
    for (int i = 0; i < 18; i++) apply(1'b0, (i % 3) == 0, MODE_BURST, 1'b0, 16'd4);
    check_cnt("burst_4", s, 4);

    // BURST of 0 is ignored
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_BURST, 1'b1, 16'd0);
    for (int i = 0; i < 10; i++) apply(1'b0, (i % 2) == 0, MODE_BURST, 1'b0, 16'd0);
    check_cnt("burst_0", s, 0);

    // BURST of 10 aborted by HALT after 3 enables
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_BURST, 1'b1, 16'd10);
    for (int i = 0; i < 9; i++) apply(1'b0, (i % 3) == 0, MODE_BURST, 1'b0, 16'd10);
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b1, MODE_HALT, 1'b0, 16'd10);
    check_cnt("burst_abort", s, 3);

    // Button held through reset must not trigger a step
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_HALT, 1'b1, 16'd0);
    repeat (2) apply(1'b1, 1'b0, MODE_STEP, 1'b1, 16'd0);
    for (int i = 0; i < 8; i++) apply(1'b0, (i % 2) == 1, MODE_STEP, 1'b1, 16'd0);
    check_cnt("held_reset", s, 0);
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_STEP, 1'b0, 16'd0);
    apply(1'b0, 1'b0, MODE_STEP, 1'b1, 16'd0);
    for (int i = 0; i < 6; i++) apply(1'b0, (i % 2) == 1, MODE_STEP, 1'b0, 16'd0);
    check_cnt("step_after_release", s, 1);

    // Back-to-back ticks in RUN wrap the narrow counter, then reset mid-RUN
    s = en_cnt;
    apply(1'b0, 1'b0, MODE_RUN, 1'b0, 16'd0);
    for (int i = 0; i < 17; i++) apply(1'b0, 1'b1, MODE_RUN, 1'b0, 16'd0);
    check_cnt("run_wrap", s, 17);
    apply(1'b1, 1'b1, MODE_RUN, 1'b0, 16'd0);
    apply(1'b0, 1'b0, MODE_HALT, 1'b0, 16'd0);

    // Randomized traffic
    rm = MODE_HALT; rstep = 1'b0; rbl = 16'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) rstep = ~rstep;
      if ($urandom_range(0, 9) == 0) rbl = CNT_W'($urandom_range(0, 5));
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, rm, rstep, rbl);
    end

    apply(1'b0, 1'b0, MODE_HALT, 1'b0, 16'd0);
    @(posedge clk_in);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
